reset_sequencer: RTL and testbench

//  Consumer side of the PLL clock/reset generator. Watches the PLL lock signal, debounces it,
//  and releases per-subsystem resets in a fixed order (bit 0 first) with programmable spacing.
//  Re-asserts every reset on lock loss and runs a soft-reset request/acknowledge handshake.

---
 rtl/reset_sequencer_pkg.sv | 20 ++
 rtl/reset_sequencer_lock_filter.sv | 60 ++++++
 rtl/reset_sequencer.sv | 140 ++++++++++++++
 tb/tb_reset_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and the
// width rule for the shared delay/soft-hold counter.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_SOFT    = 2'd3
  } state_e;

  // One counter serves both the stage spacing and the soft-reset hold, so it
  // is sized for the larger of the two terminal counts.
  function automatic int cnt_width(input int delay, input int soft_cycles);
    int m;
    m = (delay > soft_cycles) ? delay : soft_cycles;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_lock_filter.sv
// Brings the raw PLL lock into the clk domain and debounces it: lock_ok only
// rises after LOCK_FILTER consecutive high samples and drops one edge after a
// low sample is seen.
module reset_sequencer_lock_filter #(
  parameter int LOCK_FILTER = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic locked,
  output logic lock_ok
);

  localparam int FW = $clog2(LOCK_FILTER + 1);

  logic          sync1_q;
  logic          locked_s_q;
  logic [FW-1:0] cnt_q, cnt_d;
  logic          lock_ok_q, lock_ok_d;

  // Two-flop synchronizer for the asynchronous lock input.
  // NOTE: synchronizer flops are reset too, so a stale high can never reach the filter after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so both stages sample the pre-edge values (a real two-stage shift).
      sync1_q    <= locked;
      locked_s_q <= sync1_q;
    end
  end

  // Debounce counter: count clean high samples, saturate, clear on any low.
  always_comb begin
    // NOTE: defaults first so no path leaves a target unassigned (no latch).
    cnt_d     = cnt_q;
    lock_ok_d = lock_ok_q;
    if (!locked_s_q) begin
      cnt_d     = '0;
      lock_ok_d = 1'b0;
    end else begin
      if (cnt_q != FW'(LOCK_FILTER)) cnt_d = cnt_q + FW'(1);
      if (cnt_q >= FW'(LOCK_FILTER - 1)) lock_ok_d = 1'b1;
    end
  end

  // Filter state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      lock_ok_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      lock_ok_q <= lock_ok_d;
    end
  end

  assign lock_ok = lock_ok_q;

endmodule

// File: rtl/reset_sequencer.sv
// Releases per-subsystem resets in order (bit 0 first) once the PLL lock is
// stable, re-asserts them all on lock loss, and runs the soft-reset handshake.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int STAGES      = 3,
  parameter int DELAY       = 16,
  parameter int LOCK_FILTER = 4,
  parameter int SOFT_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              locked,
  input  logic              soft_req,
  output logic              soft_ack,
  output logic [STAGES-1:0] rst_out,
  output logic              ready,
  output logic [7:0]        lock_loss_cnt
);

  localparam int CNT_W = cnt_width(DELAY, SOFT_CYCLES);
  localparam int STG_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  dly_q, dly_d;
  logic [STG_W-1:0]  stage_q, stage_d;
  logic [STAGES-1:0] rst_q, rst_d;
  logic              soft_flag_q, soft_flag_d;
  logic              soft_ack_q, soft_ack_d;
  logic [7:0]        loss_q, loss_d;
  logic              soft_req_q;
  logic              soft_rise;
  logic              lock_ok;

  reset_sequencer_lock_filter #(
    .LOCK_FILTER (LOCK_FILTER)
  ) u_lock_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .locked  (locked),
    .lock_ok (lock_ok)
  );

  // Edge detector runs in every state, so a request raised outside RUN is
  // consumed there and never replayed later.
  assign soft_rise = soft_req & ~soft_req_q;

  // Next-state and output logic; lock loss outranks everything else.
  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    stage_d     = stage_q;
    rst_d       = rst_q;
    soft_flag_d = soft_flag_q;
    soft_ack_d  = 1'b0;
    loss_d      = loss_q;

    if (state_q != ST_HOLD && !lock_ok) begin
      state_d     = ST_HOLD;
      rst_d       = '1;
      soft_flag_d = 1'b0;
      if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          rst_d = '1;
          if (lock_ok) begin
            state_d = ST_RELEASE;
            dly_d   = '0;
            stage_d = '0;
          end
        end
        ST_RELEASE: begin
          if (dly_q == CNT_W'(DELAY - 1)) begin
            dly_d = '0;
            rst_d = rst_q & ~(STAGES'(1) << stage_q);
            if (stage_q == STG_W'(STAGES - 1)) begin
              state_d = ST_RUN;
              if (soft_flag_q) begin
                soft_ack_d  = 1'b1;
                soft_flag_d = 1'b0;
              end
            end else begin
              stage_d = stage_q + STG_W'(1);
            end
          end else begin
            dly_d = dly_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (soft_rise) begin
            state_d = ST_SOFT;
            rst_d   = '1;
            dly_d   = '0;
          end
        end
        ST_SOFT: begin
          if (dly_q == CNT_W'(SOFT_CYCLES - 1)) begin
            state_d     = ST_RELEASE;
            dly_d       = '0;
            stage_d     = '0;
            soft_flag_d = 1'b1;
          end else begin
            dly_d = dly_q + CNT_W'(1);
          end
        end
        default: state_d = ST_HOLD;
      endcase
    end
  end

  // FSM, counters and output registers; reset asserts every output at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_HOLD;
      dly_q       <= '0;
      stage_q     <= '0;
      rst_q       <= '1;
      soft_flag_q <= 1'b0;
      soft_ack_q  <= 1'b0;
      loss_q      <= '0;
      soft_req_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      stage_q     <= stage_d;
      rst_q       <= rst_d;
      soft_flag_q <= soft_flag_d;
      soft_ack_q  <= soft_ack_d;
      loss_q      <= loss_d;
      soft_req_q  <= soft_req;
    end
  end

  assign rst_out       = rst_q;
  assign ready         = (state_q == ST_RUN);
  assign soft_ack      = soft_ack_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with STAGES=3, DELAY=16, LOCK_FILTER=4,
// SOFT_CYCLES=8. Inputs change and outputs are sampled 1 time unit after a
// rising edge; "edge n" counts from the first edge that sees the new input.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       locked;
  logic       soft_req;
  logic       soft_ack;
  logic [2:0] rst_out;
  logic       ready;
  logic [7:0] lock_loss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  reset_sequencer #(
    .STAGES      (3),
    .DELAY       (16),
    .LOCK_FILTER (4),
    .SOFT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .locked        (locked),
    .soft_req      (soft_req),
    .soft_ack      (soft_ack),
    .rst_out       (rst_out),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         adv;      // edges to advance after applying inputs
    logic       locked;
    logic       soft_req;
    logic [2:0] rst;
    logic       rdy;
    logic       ack;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int adv, input logic l, input logic s, input logic [2:0] r,
                              input logic rdy, input logic ack, input logic [7:0] c);
    vec_t v;
    v.adv = adv; v.locked = l; v.soft_req = s; v.rst = r; v.rdy = rdy; v.ack = ack; v.cnt = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] r, input logic rdy,
                            input logic ack, input logic [7:0] cnt);
    check({tag, " rst_out"},  32'(rst_out),       32'(r));
    check({tag, " ready"},    32'(ready),         32'(rdy));
    check({tag, " soft_ack"}, 32'(soft_ack),      32'(ack));
    check({tag, " loss_cnt"}, 32'(lock_loss_cnt), 32'(cnt));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n  = 1'b1;
    locked   = 1'b0;
    soft_req = 1'b0;
    #2 reset_n = 1'b0;
    step(2);
    expect_out("reset", 3'b111, 1'b0, 1'b0, 8'd0);
    reset_n = 1'b1;

    // Power-up release timeline followed by a soft reset with soft_req held high.
    vecs.push_back(mk(22, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd0)); // edge 22
    vecs.push_back(mk( 1, 1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 8'd0)); // edge 23
    vecs.push_back(mk(15, 1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 8'd0)); // edge 38
    vecs.push_back(mk( 1, 1'b1, 1'b0, 3'b100, 1'b0, 1'b0, 8'd0)); // edge 39
    vecs.push_back(mk(15, 1'b1, 1'b0, 3'b100, 1'b0, 1'b0, 8'd0)); // edge 54
    vecs.push_back(mk( 1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 8'd0)); // edge 55
    vecs.push_back(mk( 5, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 8'd0));
    vecs.push_back(mk( 1, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 8'd0)); // soft edge s
    vecs.push_back(mk( 7, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 8'd0)); // s+7
    vecs.push_back(mk( 1, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 8'd0)); // s+8
    vecs.push_back(mk(15, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 8'd0)); // s+23
    vecs.push_back(mk( 1, 1'b1, 1'b1, 3'b110, 1'b0, 1'b0, 8'd0)); // s+24
    vecs.push_back(mk(16, 1'b1, 1'b1, 3'b100, 1'b0, 1'b0, 8'd0)); // s+40
    vecs.push_back(mk(15, 1'b1, 1'b1, 3'b100, 1'b0, 1'b0, 8'd0)); // s+55
    vecs.push_back(mk( 1, 1'b1, 1'b1, 3'b000, 1'b1, 1'b1, 8'd0)); // s+56
    vecs.push_back(mk( 1, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 8'd0)); // s+57
    vecs.push_back(mk(10, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 8'd0)); // held high, no retrigger
    vecs.push_back(mk( 2, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 8'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      locked   = vecs[i].locked;
      soft_req = vecs[i].soft_req;
      step(vecs[i].adv);
      expect_out($sformatf("vec%0d", i), vecs[i].rst, vecs[i].rdy, vecs[i].ack, vecs[i].cnt);
    end

    // Asynchronous reset while in RUN: outputs return without waiting for a clock.
    reset_n = 1'b0;
    locked  = 1'b0;
    #1;
    expect_out("async_rst", 3'b111, 1'b0, 1'b0, 8'd0);
    step(2);
    reset_n = 1'b1;

    // Glitchy lock: high 3, low 1, then high; clean lock starts at edge 5, bit 0 at edge 27.
    locked = 1'b1;
    step(3);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(22);
    expect_out("glitch e26", 3'b111, 1'b0, 1'b0, 8'd0);
    step(1);
    expect_out("glitch e27", 3'b110, 1'b0, 1'b0, 8'd0);

    // Lock loss mid-RELEASE: all resets back at the fourth edge after the drop.
    locked = 1'b0;
    step(3);
    expect_out("loss e3", 3'b110, 1'b0, 1'b0, 8'd0);
    step(1);
    expect_out("loss e4", 3'b111, 1'b0, 1'b0, 8'd1);
    locked = 1'b1;
    step(22);
    expect_out("relock e22", 3'b111, 1'b0, 1'b0, 8'd1);
    step(1);
    expect_out("relock e23", 3'b110, 1'b0, 1'b0, 8'd1);
    step(16);
    expect_out("relock e39", 3'b100, 1'b0, 1'b0, 8'd1);
    step(16);
    expect_out("relock e55", 3'b000, 1'b1, 1'b0, 8'd1);

    // Lock loss lands on the same edge as a soft_req rise: HOLD wins, no ack.
    locked = 1'b0;
    step(3);
    expect_out("race pre", 3'b000, 1'b1, 1'b0, 8'd1);
    soft_req = 1'b1;
    step(1);
    expect_out("race hit", 3'b111, 1'b0, 1'b0, 8'd2);
    step(2);
    expect_out("race after", 3'b111, 1'b0, 1'b0, 8'd2);

    // A soft_req rise seen in HOLD is dropped, not replayed once RUN is reached.
    soft_req = 1'b0;
    step(1);
    soft_req = 1'b1;
    locked   = 1'b1;
    step(22);
    expect_out("noqueue e22", 3'b111, 1'b0, 1'b0, 8'd2);
    step(33);
    expect_out("noqueue e55", 3'b000, 1'b1, 1'b0, 8'd2);
    step(5);
    expect_out("noqueue run", 3'b000, 1'b1, 1'b0, 8'd2);
    soft_req = 1'b0;

    // Saturation: 300 more lock-loss events, each caught in RELEASE.
    for (int i = 1; i <= 300; i++) begin
      locked = 1'b1;
      step(8);
      locked = 1'b0;
      step(6);
      if (i == 252) check("sat 254", 32'(lock_loss_cnt), 32'd254);
      if (i == 253) check("sat 255", 32'(lock_loss_cnt), 32'd255);
    end
    expect_out("sat end", 3'b111, 1'b0, 1'b0, 8'd255);

    // Reset clears the saturated counter immediately.
    reset_n = 1'b0;
    #1;
    expect_out("final rst", 3'b111, 1'b0, 1'b0, 8'd0);
    step(1);
    reset_n = 1'b1;
    step(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
